// File: rtl/traffic_pkg.sv
// Shared lamp codes, fault codes and monitor state encoding for the traffic safety stage.
package traffic_pkg;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;
    localparam logic [2:0] LT_OFF = 3'b000;

    localparam logic [2:0] F_NONE      = 3'd0;
    localparam logic [2:0] F_ILLEGAL   = 3'd1;
    localparam logic [2:0] F_CONFLICT  = 3'd2;
    localparam logic [2:0] F_SKIP_YEL  = 3'd3;
    localparam logic [2:0] F_SHORT_YEL = 3'd4;

    localparam int unsigned NumRoads = 4;

    typedef enum logic [1:0] {
        StMonitor = 2'd0,
        StFault   = 2'd1,
        StRecover = 2'd2
    } mon_state_e;

    // A road is "active" when it shows green or yellow, i.e. traffic may still be moving.
    function automatic logic lamp_active(input logic [2:0] code);
        return (code == LT_GRN) || (code == LT_YEL);
    endfunction

endpackage

// File: rtl/light_phase_tracker.sv
// Per-road lamp history: flags illegal codes, out-of-order phase changes and short yellows.
module light_phase_tracker
    import traffic_pkg::*;
#(
    parameter int unsigned YEL_MIN = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] code_i,
    input  logic       hist_clr_i,
    output logic       illegal_o,
    output logic       seq_err_o,
    output logic       short_yel_o
);

    localparam int unsigned CntW = $clog2(YEL_MIN) + 1;

    logic [2:0]      prev_q, prev_d;
    logic [CntW-1:0] ycnt_q, ycnt_d;

    always_comb begin
        illegal_o   = !(code_i inside {LT_RED, LT_YEL, LT_GRN});
        seq_err_o   = ((prev_q == LT_GRN) && (code_i == LT_RED)) ||
                      ((prev_q == LT_RED) && (code_i == LT_YEL)) ||
                      ((prev_q == LT_YEL) && (code_i == LT_GRN));
        short_yel_o = (prev_q == LT_YEL) && (code_i == LT_RED) &&
                      (ycnt_q < CntW'(YEL_MIN));
    end

    always_comb begin
        prev_d = code_i;
        ycnt_d = '0;
        if (code_i == LT_YEL) begin
            ycnt_d = (ycnt_q >= CntW'(YEL_MIN)) ? ycnt_q : ycnt_q + 1'b1;
        end
        if (hist_clr_i) begin
            prev_d = LT_RED;
            ycnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_q <= LT_RED;
            ycnt_q <= '0;
        end else begin
            prev_q <= prev_d;
            ycnt_q <= ycnt_d;
        end
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the light controller and lamp drivers: passes legal lamp codes with one
// cycle of latency, and on any violation latches a fault and flashes red until a verified clear.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned YEL_MIN    = 3,
    parameter int unsigned FLASH_HALF = 1,
    parameter int unsigned CLR_HOLD   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_S,
    input  logic       fault_clr,
    output logic [2:0] out_M1,
    output logic [2:0] out_M2,
    output logic [2:0] out_MT,
    output logic [2:0] out_S,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int unsigned FlW   = $clog2(FLASH_HALF) + 1;
    localparam int unsigned HoldW = $clog2(CLR_HOLD) + 1;

    mon_state_e state_q, state_d;

    logic [NumRoads-1:0][2:0] lamp_in;
    logic [NumRoads-1:0][2:0] out_q, out_d;
    logic [2:0]               fault_code_q, fault_code_d;
    logic [HoldW-1:0]         hold_q, hold_d;
    logic [FlW-1:0]           flash_cnt_q, flash_cnt_d;
    logic                     flash_red_q, flash_red_d;

    logic [NumRoads-1:0] illegal, seq_err, short_yel;
    logic                conflict, violation, all_red, hold_done, hist_clr;
    logic [2:0]          viol_code;

    // Index 0..3 = M1, M2, MT, S
    assign lamp_in = {light_S, light_MT, light_M2, light_M1};

    for (genvar i = 0; i < NumRoads; i++) begin : gen_road
        light_phase_tracker #(
            .YEL_MIN(YEL_MIN)
        ) u_tracker (
            .clk_i      (clk),
            .rst_ni     (rst),
            .code_i     (lamp_in[i]),
            .hist_clr_i (hist_clr),
            .illegal_o  (illegal[i]),
            .seq_err_o  (seq_err[i]),
            .short_yel_o(short_yel[i])
        );
    end

    always_comb begin
        conflict = (lamp_active(light_S) &&
                    (lamp_active(light_M1) || lamp_active(light_M2) || lamp_active(light_MT))) ||
                   (lamp_active(light_MT) && lamp_active(light_M2));

        // Lowest code wins when several violations coincide
        if (|illegal) begin
            viol_code = F_ILLEGAL;
        end else if (conflict) begin
            viol_code = F_CONFLICT;
        end else if (|seq_err) begin
            viol_code = F_SKIP_YEL;
        end else if (|short_yel) begin
            viol_code = F_SHORT_YEL;
        end else begin
            viol_code = F_NONE;
        end
        violation = (viol_code != F_NONE);
        all_red   = (lamp_in == {NumRoads{LT_RED}});
        hold_done = (hold_q == HoldW'(CLR_HOLD));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StMonitor;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StMonitor: if (violation) state_d = StFault;
            StFault:   if (fault_clr) state_d = StRecover;
            StRecover: if (hold_done) state_d = StMonitor;
            default:   state_d = StMonitor;
        endcase
    end

    always_comb begin
        out_d        = out_q;
        fault_code_d = fault_code_q;
        hold_d       = hold_q;
        flash_cnt_d  = flash_cnt_q;
        flash_red_d  = flash_red_q;
        hist_clr     = 1'b0;
        unique case (state_q)
            StMonitor: begin
                if (violation) begin
                    fault_code_d = viol_code;
                    out_d        = {NumRoads{LT_RED}};
                    flash_cnt_d  = '0;
                    flash_red_d  = 1'b1;
                end else begin
                    out_d = lamp_in;
                end
            end
            StFault: begin
                if (fault_clr) begin
                    out_d  = {NumRoads{LT_RED}};
                    hold_d = '0;
                end else begin
                    if (flash_cnt_q == FlW'(FLASH_HALF - 1)) begin
                        flash_cnt_d = '0;
                        flash_red_d = !flash_red_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 1'b1;
                    end
                    out_d = flash_red_d ? {NumRoads{LT_RED}} : {NumRoads{LT_OFF}};
                end
            end
            StRecover: begin
                out_d = {NumRoads{LT_RED}};
                if (hold_done) begin
                    fault_code_d = F_NONE;
                    hold_d       = '0;
                    hist_clr     = 1'b1;
                end else begin
                    hold_d = all_red ? hold_q + 1'b1 : '0;
                end
            end
            default: out_d = {NumRoads{LT_RED}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q        <= {NumRoads{LT_RED}};
            fault_code_q <= F_NONE;
            hold_q       <= '0;
            flash_cnt_q  <= '0;
            flash_red_q  <= 1'b1;
        end else begin
            out_q        <= out_d;
            fault_code_q <= fault_code_d;
            hold_q       <= hold_d;
            flash_cnt_q  <= flash_cnt_d;
            flash_red_q  <= flash_red_d;
        end
    end

    assign out_M1     = out_q[0];
    assign out_M2     = out_q[1];
    assign out_MT     = out_q[2];
    assign out_S      = out_q[3];
    assign fault      = (state_q != StMonitor);
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Vector-table bench for traffic_conflict_monitor with a queue-based expected-result scoreboard.
module tb_traffic_conflict_monitor;

    localparam logic [2:0]  R  = 3'b100;
    localparam logic [2:0]  Y  = 3'b010;
    localparam logic [2:0]  G  = 3'b001;
    localparam logic [2:0]  O  = 3'b000;
    localparam logic [2:0]  X  = 3'b011;
    localparam logic [11:0] R4 = {R, R, R, R};
    localparam logic [11:0] O4 = {O, O, O, O};

    typedef struct packed {
        logic        rst_n;
        logic        clr;
        logic [11:0] lamps;  // {M1, M2, MT, S}
        logic [11:0] eo;
        logic        ef;
        logic [2:0]  ec;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic       fault_clr;
    logic [2:0] out_M1, out_M2, out_MT, out_S;
    logic       fault;
    logic [2:0] fault_code;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [15:0] exp_q[$];
    vec_t        tbl[$];

    traffic_conflict_monitor #(
        .YEL_MIN   (3),
        .FLASH_HALF(1),
        .CLR_HOLD  (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .light_M1  (light_M1),
        .light_M2  (light_M2),
        .light_MT  (light_MT),
        .light_S   (light_S),
        .fault_clr (fault_clr),
        .out_M1    (out_M1),
        .out_M2    (out_M2),
        .out_MT    (out_MT),
        .out_S     (out_S),
        .fault     (fault),
        .fault_code(fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rn, input logic cl, input logic [11:0] in,
                                input logic [11:0] eo, input logic ef, input logic [2:0] ec);
        vec_t v;
        v.rst_n = rn;
        v.clr   = cl;
        v.lamps = in;
        v.eo    = eo;
        v.ef    = ef;
        v.ec    = ec;
        return v;
    endfunction

    // Pass-through in MONITOR: outputs equal the inputs sampled at the same edge
    function automatic vec_t pt(input logic [11:0] in);
        return mk(1'b1, 1'b0, in, in, 1'b0, 3'd0);
    endfunction

    function automatic vec_t fl(input logic cl, input logic [11:0] in, input logic [11:0] eo,
                                input logic [2:0] ec);
        return mk(1'b1, cl, in, eo, 1'b1, ec);
    endfunction

    function automatic vec_t rs(input logic [11:0] in);
        return mk(1'b0, 1'b0, in, R4, 1'b0, 3'd0);
    endfunction

    task automatic apply(input vec_t v, input int idx);
        logic [15:0] got;
        logic [15:0] exp;
        rst       = v.rst_n;
        fault_clr = v.clr;
        {light_M1, light_M2, light_MT, light_S} = v.lamps;
        exp_q.push_back({v.eo, v.ef, v.ec});
        @(posedge clk);
        #1;
        got = {out_M1, out_M2, out_MT, out_S, fault, fault_code};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL step%0d: got out=%03b_%03b_%03b_%03b fault=%b code=%0d, want out=%03b_%03b_%03b_%03b fault=%b code=%0d",
                     idx, got[15:13], got[12:10], got[9:7], got[6:4], got[3], got[2:0],
                     exp[15:13], exp[12:10], exp[9:7], exp[6:4], exp[3], exp[2:0]);
        end
    endtask

    initial begin
        rst       = 1'b0;
        fault_clr = 1'b0;
        {light_M1, light_M2, light_MT, light_S} = R4;

        // Reset state, even with junk on the inputs
        tbl.push_back(rs({X, R, R, R}));
        tbl.push_back(rs(R4));
        // Normal cycle: mains green, 3 yellows, red, then side road
        tbl.push_back(pt({G, G, R, R}));
        tbl.push_back(pt({G, G, R, R}));
        for (int i = 0; i < 3; i++) tbl.push_back(pt({Y, Y, R, R}));
        tbl.push_back(pt(R4));
        tbl.push_back(pt({R, R, R, G}));
        for (int i = 0; i < 3; i++) tbl.push_back(pt({R, R, R, Y}));
        tbl.push_back(pt(R4));
        // Conflict S with M1, flash every cycle, then clean recovery
        tbl.push_back(fl(1'b0, {G, R, R, G}, R4, 3'd2));
        tbl.push_back(fl(1'b0, {G, R, R, G}, O4, 3'd2));
        tbl.push_back(fl(1'b0, R4, R4, 3'd2));
        tbl.push_back(fl(1'b0, R4, O4, 3'd2));
        tbl.push_back(fl(1'b1, R4, R4, 3'd2));
        for (int i = 0; i < 5; i++) tbl.push_back(fl(1'b0, R4, R4, 3'd2));
        tbl.push_back(pt(R4));
        // Short yellow on M1, recovery with a hold restart at count 3
        tbl.push_back(pt({G, R, R, R}));
        tbl.push_back(pt({Y, R, R, R}));
        tbl.push_back(pt({Y, R, R, R}));
        tbl.push_back(fl(1'b0, R4, R4, 3'd4));
        tbl.push_back(fl(1'b1, R4, R4, 3'd4));
        for (int i = 0; i < 3; i++) tbl.push_back(fl(1'b0, R4, R4, 3'd4));
        tbl.push_back(fl(1'b1, {G, R, R, R}, R4, 3'd4));
        for (int i = 0; i < 5; i++) tbl.push_back(fl(1'b0, R4, R4, 3'd4));
        tbl.push_back(pt(R4));
        // M1 with MT green is legal; MT with M2 is a conflict; reset mid-fault
        tbl.push_back(pt({G, R, G, R}));
        tbl.push_back(fl(1'b0, {G, G, G, R}, R4, 3'd2));
        tbl.push_back(rs({G, G, G, R}));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Skipped yellow on M2 right after reset
        apply(pt({R, G, R, R}), 100);
        apply(fl(1'b0, R4, R4, 3'd3), 101);
        apply(fl(1'b0, R4, O4, 3'd3), 102);
        // Reset held for one edge in FAULT clears everything immediately
        apply(rs(R4), 103);
        // Illegal code together with a conflict: illegal wins, S green never driven
        apply(fl(1'b0, {X, G, R, G}, R4, 3'd1), 104);
        apply(fl(1'b0, {X, G, R, G}, O4, 3'd1), 105);
        apply(fl(1'b0, R4, R4, 3'd1), 106);
        apply(rs(R4), 107);
        apply(pt({R, R, R, G}), 108);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
